// File: rtl/seg_scan_if.sv
// Bundle between counter/datapath logic and the seven-segment scan driver.
// The master side supplies BCD values and the driver side returns the pin-level scan outputs.
interface seg_scan_if #(
  parameter int NUMDIGITS = 4
);
  logic [4*NUMDIGITS-1:0] value;
  logic                   load;
  logic                   lzb;
  logic [7:0]             seg;
  logic [NUMDIGITS-1:0]   dig_en;
  logic                   frame_done;
  logic                   pending;

  modport master (
    output value, load, lzb,
    input  seg, dig_en, frame_done, pending
  );

  modport slave (
    input  value, load, lzb,
    output seg, dig_en, frame_done, pending
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment scanner with a frame-synchronous shadow load, leading-zero and anti-ghost blanking.
// Define SEGSCAN_HEX_EN to show hex glyphs for codes 10-15 instead of the dp-only error mark.
module seg_scan_driver #(
  parameter int NUMDIGITS = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK     = 4
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUMDIGITS > 1) ? $clog2(NUMDIGITS) : 1;
  localparam int VW = 4 * NUMDIGITS;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUMDIGITS - 1);

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'b11111100;
      4'd1:    s = 8'b01100000;
      4'd2:    s = 8'b11011010;
      4'd3:    s = 8'b11110010;
      4'd4:    s = 8'b01100110;
      4'd5:    s = 8'b10110110;
      4'd6:    s = 8'b10111110;
      4'd7:    s = 8'b11100000;
      4'd8:    s = 8'b11111110;
      4'd9:    s = 8'b11110110;
`ifdef SEGSCAN_HEX_EN
      4'd10:   s = 8'b11101110;
      4'd11:   s = 8'b00111110;
      4'd12:   s = 8'b10011100;
      4'd13:   s = 8'b01111010;
      4'd14:   s = 8'b10011110;
      default: s = 8'b10001110;
`else
      default: s = 8'b00000001;
`endif
    endcase
    return s;
  endfunction

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [VW-1:0]        disp_q, disp_d;
  logic [VW-1:0]        shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic [7:0]           seg_q, seg_d;
  logic [NUMDIGITS-1:0] dig_en_q, dig_en_d;
  logic                 fdone_q;

  logic                 tick;
  logic                 boundary;
  logic [NUMDIGITS-1:0] hi_zero;
  logic                 run_zero;
  logic [3:0]           digit;
  logic                 slot_on;
  logic                 lz_blank;

  always_comb begin
    tick     = (cnt_q == CNT_LAST);
    boundary = tick && (idx_q == IDX_LAST);
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    shadow_d  = bus.load ? bus.value : shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    // A load landing on the boundary bypasses the shadow so it is not held for a whole extra frame.
    if (boundary) begin
      pending_d = 1'b0;
      if (bus.load)       disp_d = bus.value;
      else if (pending_q) disp_d = shadow_q;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    hi_zero  = '0;
    run_zero = 1'b1;
    for (int i = NUMDIGITS - 1; i >= 0; i--) begin
      run_zero   = run_zero && (disp_q[4*i +: 4] == 4'd0);
      hi_zero[i] = run_zero;
    end
    digit    = disp_q[{idx_q, 2'b00} +: 4];
    slot_on  = (cnt_q >= CNT_BLANK);
    lz_blank = bus.lzb && (idx_q != '0) && hi_zero[idx_q];
    dig_en_d = slot_on ? (NUMDIGITS'(1) << idx_q) : '0;
    seg_d    = (slot_on && !lz_blank) ? seg_encode(digit) : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= 8'h00;
      dig_en_q  <= '0;
      fdone_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_en_q  <= dig_en_d;
      fdone_q   <= boundary;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_en     = dig_en_q;
  assign bus.frame_done = fdone_q;
  assign bus.pending    = pending_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NUMDIGITS=4, PRESCALE=4, BLANK=1 (16-cycle frame).
// cyc counts rising edges since reset release; outputs after edge k reflect slot phase (k-1)%4 of digit ((k-1)/4)%4.
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

`ifdef SEGSCAN_HEX_EN
  localparam logic [7:0] GLYPH_A = 8'b11101110;
`else
  localparam logic [7:0] GLYPH_A = 8'b00000001;
`endif

  seg_scan_if #(.NUMDIGITS(4)) bus ();

  seg_scan_driver #(.NUMDIGITS(4), .PRESCALE(4), .BLANK(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    bus.lzb = 1'b0;
    do_load(16'h1234);
    run_to(6);
    total_cnt++; if (bus.dig_en !== 4'b0010) $display("FAIL pre_rst_dig_en got %b exp %b", bus.dig_en, 4'b0010); else pass_cnt++;
    total_cnt++; if (bus.pending !== 1'b1) $display("FAIL pre_rst_pending got %b exp 1", bus.pending); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.seg !== 8'h00) $display("FAIL rst_seg got %b exp 00000000", bus.seg); else pass_cnt++;
    total_cnt++; if (bus.dig_en !== 4'b0000) $display("FAIL rst_dig_en got %b exp 0000", bus.dig_en); else pass_cnt++;
    total_cnt++; if (bus.pending !== 1'b0) $display("FAIL rst_pending got %b exp 0", bus.pending); else pass_cnt++;
    total_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL rst_frame_done got %b exp 0", bus.frame_done); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    run_to(1);
    total_cnt++; if (bus.dig_en !== 4'b0000) $display("FAIL post_rst_c1_dig_en got %b exp 0000", bus.dig_en); else pass_cnt++;
    run_to(2);
    total_cnt++; if (bus.dig_en !== 4'b0001) $display("FAIL post_rst_c2_dig_en got %b exp 0001", bus.dig_en); else pass_cnt++;
    total_cnt++; if (bus.seg !== 8'b11111100) $display("FAIL post_rst_c2_seg got %b exp 11111100", bus.seg); else pass_cnt++;
    run_to(18);
    total_cnt++; if (bus.seg !== 8'b11111100) $display("FAIL rst_discard_load_seg got %b exp 11111100", bus.seg); else pass_cnt++;
  endtask

  task automatic test_scan();
    logic [7:0] newg [4];
    newg[0] = 8'b01100110;
    newg[1] = 8'b11110010;
    newg[2] = 8'b11011010;
    newg[3] = 8'b01100000;
    apply_reset();
    bus.lzb = 1'b0;
    do_load(16'h1234);
    for (int k = 1; k <= 32; k++) begin
      int p, d;
      logic [3:0] exp_dig;
      logic [7:0] exp_seg;
      logic       exp_fd, exp_pend;
      run_to(k);
      p = (k - 1) % 4;
      d = ((k - 1) / 4) % 4;
      exp_dig  = (p >= 1) ? (4'b0001 << d) : 4'b0000;
      exp_seg  = (p == 0) ? 8'h00 : ((k <= 16) ? 8'b11111100 : newg[d]);
      exp_fd   = (k % 16 == 0);
      exp_pend = (k < 16);
      total_cnt++; if (bus.dig_en !== exp_dig) $display("FAIL scan_dig_en k=%0d got %b exp %b", k, bus.dig_en, exp_dig); else pass_cnt++;
      total_cnt++; if (bus.seg !== exp_seg) $display("FAIL scan_seg k=%0d got %b exp %b", k, bus.seg, exp_seg); else pass_cnt++;
      total_cnt++; if (bus.frame_done !== exp_fd) $display("FAIL scan_frame_done k=%0d got %b exp %b", k, bus.frame_done, exp_fd); else pass_cnt++;
      total_cnt++; if (bus.pending !== exp_pend) $display("FAIL scan_pending k=%0d got %b exp %b", k, bus.pending, exp_pend); else pass_cnt++;
    end
  endtask

  task automatic test_shadow();
    apply_reset();
    bus.lzb = 1'b0;
    do_load(16'h1234);
    run_to(21);
    do_load(16'h0007);
    total_cnt++; if (bus.pending !== 1'b1) $display("FAIL shadow_pending_set got %b exp 1", bus.pending); else pass_cnt++;
    run_to(23);
    total_cnt++; if (bus.seg !== 8'b11110010) $display("FAIL shadow_hold_d1 got %b exp 11110010", bus.seg); else pass_cnt++;
    run_to(30);
    total_cnt++; if (bus.seg !== 8'b01100000) $display("FAIL shadow_hold_d3 got %b exp 01100000", bus.seg); else pass_cnt++;
    run_to(31);
    total_cnt++; if (bus.pending !== 1'b1) $display("FAIL shadow_pending_hold got %b exp 1", bus.pending); else pass_cnt++;
    run_to(32);
    total_cnt++; if (bus.pending !== 1'b0) $display("FAIL shadow_pending_clr got %b exp 0", bus.pending); else pass_cnt++;
    run_to(34);
    total_cnt++; if (bus.seg !== 8'b11100000) $display("FAIL shadow_new_d0 got %b exp 11100000", bus.seg); else pass_cnt++;
    run_to(38);
    total_cnt++; if (bus.seg !== 8'b11111100) $display("FAIL shadow_new_d1 got %b exp 11111100", bus.seg); else pass_cnt++;
  endtask

  task automatic test_lzb();
    apply_reset();
    bus.lzb = 1'b1;
    do_load(16'h0007);
    run_to(18);
    total_cnt++; if (bus.seg !== 8'b11100000) $display("FAIL lzb_7_d0 got %b exp 11100000", bus.seg); else pass_cnt++;
    run_to(22);
    total_cnt++; if (bus.seg !== 8'h00) $display("FAIL lzb_7_d1 got %b exp 00000000", bus.seg); else pass_cnt++;
    total_cnt++; if (bus.dig_en !== 4'b0010) $display("FAIL lzb_7_d1_en got %b exp 0010", bus.dig_en); else pass_cnt++;
    run_to(25);
    do_load(16'h0000);
    total_cnt++; if (bus.seg !== 8'h00) $display("FAIL lzb_7_d2 got %b exp 00000000", bus.seg); else pass_cnt++;
    run_to(30);
    total_cnt++; if (bus.seg !== 8'h00) $display("FAIL lzb_7_d3 got %b exp 00000000", bus.seg); else pass_cnt++;
    run_to(34);
    total_cnt++; if (bus.seg !== 8'b11111100) $display("FAIL lzb_0_d0 got %b exp 11111100", bus.seg); else pass_cnt++;
    run_to(38);
    total_cnt++; if (bus.seg !== 8'h00) $display("FAIL lzb_0_d1 got %b exp 00000000", bus.seg); else pass_cnt++;
    run_to(40);
    bus.lzb = 1'b0;
    do_load(16'h0007);
    run_to(50);
    total_cnt++; if (bus.seg !== 8'b11100000) $display("FAIL nolzb_7_d0 got %b exp 11100000", bus.seg); else pass_cnt++;
    for (int k = 54; k <= 62; k += 4) begin
      run_to(k);
      total_cnt++; if (bus.seg !== 8'b11111100) $display("FAIL nolzb_7_hi k=%0d got %b exp 11111100", k, bus.seg); else pass_cnt++;
    end
  endtask

  task automatic test_err_code();
    apply_reset();
    bus.lzb = 1'b0;
    do_load(16'h000A);
    run_to(18);
    total_cnt++; if (bus.seg !== GLYPH_A) $display("FAIL code_a_d0 got %b exp %b", bus.seg, GLYPH_A); else pass_cnt++;
    run_to(20);
    bus.lzb = 1'b1;
    do_load(16'h0A00);
    run_to(34);
    total_cnt++; if (bus.seg !== 8'b11111100) $display("FAIL lzb_a00_d0 got %b exp 11111100", bus.seg); else pass_cnt++;
    run_to(38);
    total_cnt++; if (bus.seg !== 8'b11111100) $display("FAIL lzb_a00_d1 got %b exp 11111100", bus.seg); else pass_cnt++;
    run_to(42);
    total_cnt++; if (bus.seg !== GLYPH_A) $display("FAIL lzb_a00_d2 got %b exp %b", bus.seg, GLYPH_A); else pass_cnt++;
    run_to(46);
    total_cnt++; if (bus.seg !== 8'h00) $display("FAIL lzb_a00_d3 got %b exp 00000000", bus.seg); else pass_cnt++;
  endtask

  task automatic test_boundary_load();
    apply_reset();
    bus.lzb = 1'b0;
    run_to(5);
    do_load(16'h1234);
    total_cnt++; if (bus.pending !== 1'b1) $display("FAIL bnd_pre_pending got %b exp 1", bus.pending); else pass_cnt++;
    run_to(15);
    do_load(16'h5555);
    total_cnt++; if (bus.pending !== 1'b0) $display("FAIL bnd_pending got %b exp 0", bus.pending); else pass_cnt++;
    total_cnt++; if (bus.frame_done !== 1'b1) $display("FAIL bnd_frame_done got %b exp 1", bus.frame_done); else pass_cnt++;
    run_to(17);
    total_cnt++; if (bus.pending !== 1'b0) $display("FAIL bnd_pending_after got %b exp 0", bus.pending); else pass_cnt++;
    total_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL bnd_frame_done_after got %b exp 0", bus.frame_done); else pass_cnt++;
    for (int k = 18; k <= 30; k += 4) begin
      run_to(k);
      total_cnt++; if (bus.seg !== 8'b10110110) $display("FAIL bnd_5555 k=%0d got %b exp 10110110", k, bus.seg); else pass_cnt++;
    end
  endtask

  initial begin
    bus.value = '0;
    bus.load  = 1'b0;
    bus.lzb   = 1'b0;
    test_reset();
    test_scan();
    test_shadow();
    test_lzb();
    test_err_code();
    test_boundary_load();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
